mult_seq_ctrl: RTL and testbench

- Sequencer that drives one shared combinational 16-bit adder (ports c, d, cin -> s, cout) as a radix-2 shift-and-add multiplier.
- Produces a 2*WIDTH-bit unsigned product from two WIDTH-bit operands over WIDTH iterations.
- The adder is instantiated by the parent and wired to this block's add_* ports.
- The block owns operand/product registers, iteration counter, FSM and start/done handshake.

---
 rtl/mult_seq_pkg.sv | 13 +
 rtl/mult_seq_cnt.sv | 26 ++
 rtl/mult_seq_ctrl.sv | 99 +++++++++
 tb/tb_mult_seq_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// Shared state encoding and default sizing for the sequential shift-and-add multiplier.
package mult_seq_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_seq_cnt.sv
// Iteration counter for mult_seq_ctrl; flags the final iteration (cnt == WIDTH-1).
module mult_seq_cnt #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_seq_ctrl.sv
// Radix-2 shift-and-add multiply sequencer driving an external WIDTH-bit adder.
// Optional build macro MULT_SEQ_ZERO_BYPASS_EN: zero operands skip RUN and finish in one cycle.
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_c,
  output logic [WIDTH-1:0]   add_d,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_s,
  input  logic               add_cout
);

  state_t           state;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;
  logic             accept;
  logic             bypass;
  logic             cnt_last;

  assign accept = start && (state == ST_IDLE || state == ST_DONE);

`ifdef MULT_SEQ_ZERO_BYPASS_EN
  assign bypass = (a == '0) || (b == '0);
`else
  assign bypass = 1'b0;
`endif

  mult_seq_cnt #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (state == ST_RUN),
    .last (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset too, since product must read 0 after reset.
      state <= ST_IDLE;
      m_reg <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            m_reg <= a;
            p_hi  <= '0;
            p_lo  <= bypass ? '0 : b;
            state <= bypass ? ST_DONE : ST_RUN;
            busy  <= !bypass;
            done  <= bypass;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        ST_RUN: begin
          // Carry lands in the top bit before the shift, so the product never overflows.
          {p_hi, p_lo} <= {add_cout, add_s, p_lo[WIDTH-1:1]};
          if (cnt_last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign product = {p_hi, p_lo};
  assign add_c   = p_hi;
  assign add_d   = (state == ST_RUN && p_lo[0]) ? m_reg : '0;
  assign add_cin = 1'b0;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl with a behavioural external adder.
module tb_mult_seq_ctrl;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;
  localparam int NORM_LAT = WIDTH + 1;
  localparam int NORM_BUSY = WIDTH;
`ifdef MULT_SEQ_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 1;
  localparam int ZERO_BUSY = 0;
`else
  localparam int ZERO_LAT = NORM_LAT;
  localparam int ZERO_BUSY = NORM_BUSY;
`endif

  logic               clk;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   add_c;
  logic [WIDTH-1:0]   add_d;
  logic               add_cin;
  logic [WIDTH-1:0]   add_s;
  logic               add_cout;
  logic [WIDTH:0]     sum_full;

  int n_checks = 0;
  int n_fail   = 0;

  mult_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .add_c    (add_c),
    .add_d    (add_d),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  assign sum_full = {1'b0, add_c} + {1'b0, add_d} + {{WIDTH{1'b0}}, add_cin};
  assign add_s    = sum_full[WIDTH-1:0];
  assign add_cout = sum_full[WIDTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] p;
    int                 lat;
    int                 bsy;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts edges (from the start edge) until done, bounded.
  task automatic wait_done(input int lat0, output int lat, output int bc);
    lat = lat0;
    bc  = 0;
    while (!done && lat < 64) begin
      bc += int'(busy);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [2*WIDTH-1:0] exp, input int exp_lat, input int exp_bsy);
    int lat;
    int bc;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, lat, bc);
    check({name, " latency"}, lat, exp_lat);
    check({name, " busy_cycles"}, bc, exp_bsy);
    check({name, " product"}, product, exp);
    @(negedge clk);
    check({name, " idle_after"}, {busy, done}, 2'b00);
    check({name, " held"}, product, exp);
  endtask

  initial begin
    int lat;
    int bc;
    int n_cout;
    logic [WIDTH-1:0] ph, pl, m;
    logic [WIDTH:0]   s;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F, NORM_LAT, NORM_BUSY};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001, NORM_LAT, NORM_BUSY};
    vecs[2] = '{16'h0007, 16'h0009, 32'h0000_003F, NORM_LAT, NORM_BUSY};
    vecs[3] = '{16'h1234, 16'h0100, 32'h0012_3400, NORM_LAT, NORM_BUSY};
    vecs[4] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF, NORM_LAT, NORM_BUSY};
    vecs[5] = '{16'h8000, 16'h0002, 32'h0001_0000, NORM_LAT, NORM_BUSY};
    vecs[6] = '{16'h0000, 16'hABCD, 32'h0000_0000, ZERO_LAT, ZERO_BUSY};
    vecs[7] = '{16'hABCD, 16'h0000, 32'h0000_0000, ZERO_LAT, ZERO_BUSY};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy_done", {busy, done}, 2'b00);
    check("reset product", product, 0);
    check("reset add_d", add_d, 0);
    check("reset add_cin", add_cin, 0);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat, vecs[i].bsy);
    end

    // Step-by-step model of 0xFFFF*0xFFFF, following add_cout into the top bit.
    m = 16'hFFFF; ph = '0; pl = 16'hFFFF; n_cout = 0;
    @(negedge clk);
    a = m; b = pl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      s = {1'b0, ph} + {1'b0, (pl[0] ? m : {WIDTH{1'b0}})};
      check($sformatf("step%0d add_d", k), add_d, pl[0] ? m : {WIDTH{1'b0}});
      check($sformatf("step%0d add_cout", k), add_cout, s[WIDTH]);
      if (s[WIDTH]) n_cout++;
      {ph, pl} = {s, pl[WIDTH-1:1]};
      @(negedge clk);
      check($sformatf("step%0d P", k), product, {ph, pl});
    end
    check("ffff carries seen", n_cout > 0, 1'b1);
    check("ffff done", done, 1'b1);
    check("ffff final", product, 32'hFFFE_0001);

    // start during RUN is ignored.
    @(negedge clk);
    a = 16'd7; b = 16'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a = 16'd1; b = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, lat, bc);
    check("ignore latency", lat, NORM_LAT);
    check("ignore product", product, 32'h3F);

    // Synchronous reset mid-RUN discards the operation.
    @(negedge clk);
    @(negedge clk);
    a = 16'h1234; b = 16'h0100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst busy_done", {busy, done}, 2'b00);
    check("rst product", product, 0);
    run_op("after_rst", 16'd2, 16'd3, 32'h6, NORM_LAT, NORM_BUSY);

    // Back-to-back: new start accepted in DONE goes straight to RUN.
    @(negedge clk);
    a = 16'd4; b = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, lat, bc);
    check("b2b first latency", lat, NORM_LAT);
    check("b2b first product", product, 32'h10);
    a = 16'h00FF; b = 16'h0002; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b no idle gap", {busy, done}, 2'b10);
    wait_done(1, lat, bc);
    check("b2b second latency", lat, NORM_LAT);
    check("b2b second product", product, 32'h1FE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
